// File: rtl/vector_pkg.sv
//------------------------------------------------------------------------------
// Module   : vector_pkg
// Brief    : Shared vector LSU constants, state encoding and MEM opcodes.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vector_pkg;

    localparam int VL         = 8;
    localparam int SEW        = 32;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = (VL > 1) ? $clog2(VL) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Major opcodes MEM decodes to form req_write (LOAD-FP / STORE-FP)
    localparam logic [6:0] INST_VLE32 = 7'b0000111;
    localparam logic [6:0] INST_VSE32 = 7'b0100111;

endpackage

`default_nettype wire

// File: rtl/vlsu_addr_gen.sv
//------------------------------------------------------------------------------
// Module   : vlsu_addr_gen
// Brief    : Element counter and beat address accumulator (optional stride).
//            Build option: VLSU_STRIDE_EN
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vlsu_addr_gen
    import vector_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      base,
`ifdef VLSU_STRIDE_EN
    input  logic [31:0]      stride,
`endif
    output logic             last,
    output logic [CNT_W-1:0] cnt,
    output logic [31:0]      addr
);

`ifdef VLSU_STRIDE_EN
    logic [31:0] stride_q;
`endif

    // Accumulating the stride yields base + i*stride modulo 2^32 without a multiplier
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            addr     <= '0;
`ifdef VLSU_STRIDE_EN
            stride_q <= '0;
`endif
        end else if (load) begin
            cnt      <= '0;
            addr     <= base;
`ifdef VLSU_STRIDE_EN
            stride_q <= stride;
`endif
        end else if (step) begin
            cnt      <= cnt + CNT_W'(1);
`ifdef VLSU_STRIDE_EN
            addr     <= addr + stride_q;
`else
            addr     <= addr + 32'(WORD_BYTES);
`endif
        end
    end

    assign last = (cnt == CNT_W'(VL - 1));

endmodule

`default_nettype wire

// File: rtl/vector_lsu.sv
//------------------------------------------------------------------------------
// Module   : vector_lsu
// Brief    : Unit-stride vector load/store sequencer over the D_ memory bus.
//            Build option: VLSU_STRIDE_EN (adds req_stride)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vector_lsu
    import vector_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_base,
`ifdef VLSU_STRIDE_EN
    input  logic [31:0]       req_stride,
`endif
    input  logic [VL*SEW-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic [VL*SEW-1:0] ld_data,
    output logic              D_enable,
    output logic              D_write,
    output logic [31:0]       D_addr,
    output logic [31:0]       D_wdata,
    input  logic              D_ready,
    input  logic [31:0]       D_rdata
);

    state_t                    state;
    logic [VL-1:0][SEW-1:0]    wdata_q;
    logic [VL-1:0][SEW-1:0]    ld_q;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          nxt;
    logic                      last;
    logic                      accept;
    logic                      step;

    assign accept = (state == ST_IDLE) && req_valid;
    assign step   = (state == ST_ACCESS) && D_ready && !last;
    assign nxt    = cnt + CNT_W'(1);

    vlsu_addr_gen u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (step),
        .base   (req_base),
`ifdef VLSU_STRIDE_EN
        .stride (req_stride),
`endif
        .last   (last),
        .cnt    (cnt),
        .addr   (D_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            D_enable <= 1'b0;
            D_write  <= 1'b0;
            D_wdata  <= '0;
            done     <= 1'b0;
            ld_q     <= '0;
            wdata_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wdata_q  <= req_wdata;
                        D_enable <= 1'b1;
                        D_write  <= req_write;
                        D_wdata  <= req_wdata[SEW-1:0];
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // D_enable is always high here, so D_ready alone marks a completed beat
                    if (D_ready) begin
                        if (!D_write) begin
                            ld_q[cnt] <= D_rdata;
                        end
                        if (last) begin
                            D_enable <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            D_wdata  <= wdata_q[nxt];
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign ld_data   = ld_q;

endmodule

`default_nettype wire
